// File: rtl/hit_memory_sequencer_pkg.sv
// Shared widths and phase encoding for the hit-bitmap storage path.
// The storage and readout blocks decode seq_state_t to follow the current phase.
package hit_memory_sequencer_pkg;

  localparam int MEMNROWS     = 16;
  localparam int ROWINDEXBITS = $clog2(MEMNROWS);
  localparam int COLINDEXBITS = 4;
  localparam int ADDRBITS     = ROWINDEXBITS + COLINDEXBITS;
  localparam int HITCOUNTBITS = 16;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_STORE,
    SEQ_CLEAR_STROBE,
    SEQ_CLEAR_WAIT,
    SEQ_DRAIN,
    SEQ_READ_STROBE,
    SEQ_READ_WAIT
  } seq_state_t;

endpackage

// File: rtl/hit_memory_sequencer_fifo.sv
// Synchronous address FIFO with full/empty flags, occupancy count and flush.
// Flush wins over a same-cycle push so that no stale hit survives a clear.
module hit_addr_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           data_in,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; count alone decides
  // which entries are valid, so the array can map onto plain RAM.
  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_ptr] <= data_in;
  end

endmodule

// File: rtl/hit_memory_sequencer.sv
// Sequences the hit-bitmap storage through clear, store and readout phases,
// buffering incoming hit addresses in a small FIFO.
module hit_memory_sequencer
  import hit_memory_sequencer_pkg::*;
#(
  parameter int FIFODEPTH = 8,
  parameter int TIMEOUT   = 64
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    addrValid,
  input  logic [ADDRBITS-1:0]     addrIn,
  output logic                    addrReady,
  input  logic                    startClear,
  input  logic                    startReadout,
  output logic                    clearMemory,
  output logic                    readMemory,
  output logic                    newAddress,
  output logic [ADDRBITS-1:0]     address,
  input  logic                    storageReady,
  input  logic                    readReady,
  output logic                    busy,
  output logic                    clearDone,
  output logic                    readoutDone,
  output logic [HITCOUNTBITS-1:0] hitCount,
  output logic                    timeoutError
);

  localparam int CW = $clog2(FIFODEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMEOUT_CNT = TW'(TIMEOUT);

  seq_state_t          state, state_d;
  logic                ready_en;
  logic                clr_pend, rd_pend, clr_pend_clr, rd_pend_clr;
  logic                gap, gap_d;
  logic                seen_low, seen_low_d;
  logic [CW-1:0]       drain_cnt, drain_cnt_d;
  logic [TW-1:0]       wait_cnt, wait_cnt_d, wait_cnt_inc;
  logic                wait_expired;
  logic                fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [ADDRBITS-1:0] fifo_head;
  logic [CW-1:0]       fifo_count;
  logic                new_address_d, clear_memory_d, read_memory_d;
  logic                clear_done_d, readout_done_d;
  logic [ADDRBITS-1:0] address_d;
  logic                hit_inc, hit_zero, timeout_set;
  logic                in_clear;

  hit_addr_fifo #(
    .WIDTH (ADDRBITS),
    .DEPTH (FIFODEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .flush   (fifo_flush),
    .data_in (addrIn),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // ready_en holds addrReady low for the whole reset and releases it one edge later.
  assign in_clear     = (state == SEQ_CLEAR_STROBE) || (state == SEQ_CLEAR_WAIT);
  assign addrReady    = ready_en && !fifo_full && !in_clear;
  assign fifo_push    = addrValid && addrReady;
  assign busy         = (state != SEQ_IDLE) || !fifo_empty;
  assign wait_cnt_inc = wait_cnt + TW'(1);
  assign wait_expired = (wait_cnt_inc == TIMEOUT_CNT);

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d        = state;
    gap_d          = 1'b0;
    seen_low_d     = 1'b0;
    drain_cnt_d    = drain_cnt;
    wait_cnt_d     = '0;
    fifo_pop       = 1'b0;
    fifo_flush     = 1'b0;
    new_address_d  = 1'b0;
    address_d      = address;
    clear_memory_d = 1'b0;
    read_memory_d  = 1'b0;
    clear_done_d   = 1'b0;
    readout_done_d = 1'b0;
    hit_inc        = 1'b0;
    hit_zero       = 1'b0;
    timeout_set    = 1'b0;
    clr_pend_clr   = 1'b0;
    rd_pend_clr    = 1'b0;

    case (state)
      SEQ_IDLE: begin
        if (clr_pend) begin
          fifo_flush = 1'b1;
          state_d    = SEQ_CLEAR_STROBE;
        end else if (rd_pend) begin
          drain_cnt_d = fifo_count;
          state_d     = SEQ_DRAIN;
        end else if (!fifo_empty) begin
          state_d = SEQ_STORE;
        end
      end

      SEQ_STORE: begin
        if (gap) begin
          if (fifo_empty || clr_pend || rd_pend) state_d = SEQ_IDLE;
        end else if (fifo_empty) begin
          state_d = SEQ_IDLE;
        end else if (storageReady) begin
          fifo_pop      = 1'b1;
          new_address_d = 1'b1;
          address_d     = fifo_head;
          hit_inc       = 1'b1;
          gap_d         = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_inc;
          if (wait_expired) begin
            timeout_set = 1'b1;
            state_d     = SEQ_IDLE;
          end
        end
      end

      SEQ_DRAIN: begin
        // Only entries present at entry are drained; later pushes wait.
        if (!gap) begin
          if (!storageReady) begin
            wait_cnt_d = wait_cnt_inc;
            if (wait_expired) begin
              timeout_set = 1'b1;
              rd_pend_clr = 1'b1;
              state_d     = SEQ_IDLE;
            end
          end else if (drain_cnt != '0) begin
            fifo_pop      = 1'b1;
            new_address_d = 1'b1;
            address_d     = fifo_head;
            hit_inc       = 1'b1;
            gap_d         = 1'b1;
            drain_cnt_d   = drain_cnt - CW'(1);
          end else begin
            state_d = SEQ_READ_STROBE;
          end
        end
      end

      SEQ_CLEAR_STROBE: begin
        clear_memory_d = 1'b1;
        state_d        = SEQ_CLEAR_WAIT;
      end

      SEQ_CLEAR_WAIT: begin
        if (seen_low && readReady) begin
          clear_done_d = 1'b1;
          hit_zero     = 1'b1;
          clr_pend_clr = 1'b1;
          state_d      = SEQ_IDLE;
        end else begin
          seen_low_d = seen_low || !readReady;
          wait_cnt_d = wait_cnt_inc;
          if (wait_expired) begin
            timeout_set  = 1'b1;
            clr_pend_clr = 1'b1;
            state_d      = SEQ_IDLE;
          end
        end
      end

      SEQ_READ_STROBE: begin
        read_memory_d = 1'b1;
        state_d       = SEQ_READ_WAIT;
      end

      SEQ_READ_WAIT: begin
        if (seen_low && readReady) begin
          readout_done_d = 1'b1;
          rd_pend_clr    = 1'b1;
          state_d        = SEQ_IDLE;
        end else begin
          seen_low_d = seen_low || !readReady;
          wait_cnt_d = wait_cnt_inc;
          if (wait_expired) begin
            timeout_set = 1'b1;
            rd_pend_clr = 1'b1;
            state_d     = SEQ_IDLE;
          end
        end
      end

      default: state_d = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= SEQ_IDLE;
      ready_en     <= 1'b0;
      clr_pend     <= 1'b0;
      rd_pend      <= 1'b0;
      gap          <= 1'b0;
      seen_low     <= 1'b0;
      drain_cnt    <= '0;
      wait_cnt     <= '0;
      newAddress   <= 1'b0;
      address      <= '0;
      clearMemory  <= 1'b0;
      readMemory   <= 1'b0;
      clearDone    <= 1'b0;
      readoutDone  <= 1'b0;
      hitCount     <= '0;
      timeoutError <= 1'b0;
    end else begin
      state        <= state_d;
      ready_en     <= 1'b1;
      clr_pend     <= !clr_pend_clr && (clr_pend || startClear);
      rd_pend      <= !rd_pend_clr && (rd_pend || startReadout);
      gap          <= gap_d;
      seen_low     <= seen_low_d;
      drain_cnt    <= drain_cnt_d;
      wait_cnt     <= wait_cnt_d;
      newAddress   <= new_address_d;
      address      <= address_d;
      clearMemory  <= clear_memory_d;
      readMemory   <= read_memory_d;
      clearDone    <= clear_done_d;
      readoutDone  <= readout_done_d;
      if (hit_zero) begin
        hitCount <= '0;
      end else if (hit_inc && (hitCount != '1)) begin
        hitCount <= hitCount + HITCOUNTBITS'(1);
      end
      if (timeout_set) timeoutError <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hit_memory_sequencer.sv
// Directed bench for hit_memory_sequencer with a small storage-unit model that
// answers clear/readout strobes with a readReady low-then-high handshake.
module tb_hit_memory_sequencer;

  localparam int EV_NEW     = 0;
  localparam int EV_CLR     = 1;
  localparam int EV_RD      = 2;
  localparam int EV_CLRDONE = 3;
  localparam int EV_RDDONE  = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        addrValid = 1'b0;
  logic [7:0]  addrIn = 8'h00;
  logic        startClear = 1'b0;
  logic        startReadout = 1'b0;
  logic        storageReady = 1'b0;
  logic        readReady = 1'b1;
  logic        addrReady, clearMemory, readMemory, newAddress;
  logic        busy, clearDone, readoutDone, timeoutError;
  logic [7:0]  address;
  logic [15:0] hitCount;

  hit_memory_sequencer #(
    .FIFODEPTH (8),
    .TIMEOUT   (64)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .addrValid    (addrValid),
    .addrIn       (addrIn),
    .addrReady    (addrReady),
    .startClear   (startClear),
    .startReadout (startReadout),
    .clearMemory  (clearMemory),
    .readMemory   (readMemory),
    .newAddress   (newAddress),
    .address      (address),
    .storageReady (storageReady),
    .readReady    (readReady),
    .busy         (busy),
    .clearDone    (clearDone),
    .readoutDone  (readoutDone),
    .hitCount     (hitCount),
    .timeoutError (timeoutError)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  int ncyc = 0;
  always @(posedge clock) ncyc <= ncyc + 1;

  // Event log, sampled on the falling edge.
  int         n_new, n_clr, n_rd, n_clrdone, n_rddone;
  int         rd_cyc, clrdone_cyc, rddone_cyc, rise_cyc;
  logic [7:0] addr_q[$];
  int         cyc_q[$];

  always @(negedge clock) begin
    if (!reset) begin
      if (newAddress) begin
        addr_q.push_back(address);
        cyc_q.push_back(ncyc);
        n_new++;
      end
      if (clearMemory) n_clr++;
      if (readMemory) begin
        n_rd++;
        rd_cyc = ncyc;
      end
      if (clearDone) begin
        n_clrdone++;
        clrdone_cyc = ncyc;
      end
      if (readoutDone) begin
        n_rddone++;
        rddone_cyc = ncyc;
      end
    end
  end

  // Storage model: readReady low for three cycles starting two cycles after a
  // strobe; with hang set it never comes back high.
  int   phase_cnt = 0;
  logic hang = 1'b0;
  logic new_rr;
  always @(negedge clock) begin
    if (reset) begin
      phase_cnt = 0;
      readReady = 1'b1;
    end else begin
      if (clearMemory || readMemory) phase_cnt = 1;
      else if (phase_cnt != 0) phase_cnt++;
      if (phase_cnt >= 6 && !hang) phase_cnt = 0;
      new_rr = !(phase_cnt >= 3 && (hang || phase_cnt <= 5));
      if (!readReady && new_rr) rise_cyc = ncyc;
      readReady = new_rr;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  function automatic int evt_count(input int sel);
    case (sel)
      EV_NEW:     return n_new;
      EV_CLR:     return n_clr;
      EV_RD:      return n_rd;
      EV_CLRDONE: return n_clrdone;
      default:    return n_rddone;
    endcase
  endfunction

  task automatic wait_evt(input string tag, input int sel, input int base, input int budget);
    int g = 0;
    while (evt_count(sel) == base && g < budget) begin
      step();
      g++;
    end
    check(tag, 32'(evt_count(sel) != base), 1);
  endtask

  task automatic push(input logic [7:0] a);
    int g = 0;
    addrValid = 1'b1;
    addrIn    = a;
    while (!addrReady && g < 200) begin
      step();
      g++;
    end
    check($sformatf("push_%02h_accepted", a), 32'(addrReady), 1);
    step();
    addrValid = 1'b0;
  endtask

  function automatic logic [31:0] all_outs();
    return {addrReady, clearMemory, readMemory, newAddress, busy, clearDone,
            readoutDone, timeoutError, address, hitCount};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int base, b_clr, b_rd, b_cd, b_rdd, g;

  initial begin
    // Reset values and first ready cycle
    step(2);
    check("reset_outputs", all_outs(), 32'h0);
    reset = 1'b0;
    step();
    check("ready_after_reset", 32'(addrReady), 1);

    // Three stores, one idle cycle between strobes
    storageReady = 1'b1;
    base = n_new;
    push(8'h12);
    push(8'h34);
    push(8'h35);
    step(10);
    check("t1_store_count", 32'(n_new - base), 3);
    check("t1_addr0", 32'(addr_q[base]), 32'h12);
    check("t1_addr1", 32'(addr_q[base+1]), 32'h34);
    check("t1_addr2", 32'(addr_q[base+2]), 32'h35);
    check("t1_spacing01", 32'(cyc_q[base+1] - cyc_q[base]), 2);
    check("t1_spacing12", 32'(cyc_q[base+2] - cyc_q[base+1]), 2);
    check("t1_hit_count", 32'(hitCount), 3);

    // Fill the FIFO while storage stalls, then release
    storageReady = 1'b0;
    base = n_new;
    for (int i = 0; i < 8; i++) push(8'h80 + 8'(i));
    check("t2_full_not_ready", 32'(addrReady), 0);
    fork
      push(8'h88);
      begin
        step(3);
        check("t2_still_full", 32'(addrReady), 0);
        storageReady = 1'b1;
      end
    join
    step(25);
    check("t2_store_count", 32'(n_new - base), 9);
    for (int i = 0; i < 9; i++)
      check($sformatf("t2_addr%0d", i), 32'(addr_q[base+i]), 32'h80 + 32'(i));
    check("t2_hit_count", 32'(hitCount), 12);

    // Clear and readout requested together; queued hits are discarded
    base  = n_new;
    b_clr = n_clr;
    b_cd  = n_clrdone;
    b_rd  = n_rd;
    b_rdd = n_rddone;
    startClear   = 1'b1;
    startReadout = 1'b1;
    addrValid    = 1'b1;
    addrIn       = 8'h21;
    step();
    startClear   = 1'b0;
    startReadout = 1'b0;
    addrIn       = 8'h22;
    step();
    addrValid = 1'b0;
    wait_evt("t3_clear_done", EV_CLRDONE, b_cd, 60);
    check("t3_hit_count_zero", 32'(hitCount), 0);
    check("t3_clear_strobes", 32'(n_clr - b_clr), 1);
    wait_evt("t3_readout_done", EV_RDDONE, b_rdd, 60);
    check("t3_read_strobes", 32'(n_rd - b_rd), 1);
    check("t3_clear_before_read", 32'(clrdone_cyc < rd_cyc), 1);
    check("t3_no_stores", 32'(n_new - base), 0);
    step();
    check("t3_idle_flushed", 32'(busy), 0);

    // Readout drains three queued entries first
    storageReady = 1'b0;
    base  = n_new;
    b_rd  = n_rd;
    b_rdd = n_rddone;
    push(8'h41);
    push(8'h42);
    push(8'h43);
    startReadout = 1'b1;
    step();
    startReadout = 1'b0;
    step(2);
    storageReady = 1'b1;
    wait_evt("t4_readout_done", EV_RDDONE, b_rdd, 100);
    check("t4_store_count", 32'(n_new - base), 3);
    check("t4_addr0", 32'(addr_q[base]), 32'h41);
    check("t4_addr1", 32'(addr_q[base+1]), 32'h42);
    check("t4_addr2", 32'(addr_q[base+2]), 32'h43);
    check("t4_stores_before_read", 32'(cyc_q[base+2] < rd_cyc), 1);
    check("t4_done_after_rise", 32'(rddone_cyc - rise_cyc), 1);
    check("t4_hit_count", 32'(hitCount), 3);

    // Clear handshake never completes
    hang  = 1'b1;
    b_clr = n_clr;
    b_cd  = n_clrdone;
    startClear = 1'b1;
    step();
    startClear = 1'b0;
    wait_evt("t5_clear_strobe", EV_CLR, b_clr, 20);
    step(60);
    check("t5_no_early_timeout", 32'(timeoutError), 0);
    g = 0;
    while (!timeoutError && g < 15) begin
      step();
      g++;
    end
    check("t5_timeout_error", 32'(timeoutError), 1);
    check("t5_back_idle", 32'(busy), 0);
    check("t5_no_clear_done", 32'(n_clrdone - b_cd), 0);
    check("t5_hit_count_kept", 32'(hitCount), 3);
    hang = 1'b0;
    step(3);

    // Reset asserted during readout wait
    push(8'h77);
    step(4);
    check("t6_hit_count_before", 32'(hitCount), 4);
    b_rd  = n_rd;
    b_rdd = n_rddone;
    startReadout = 1'b1;
    step();
    startReadout = 1'b0;
    wait_evt("t6_read_strobe", EV_RD, b_rd, 30);
    step();
    #1 reset = 1'b1;
    #1;
    check("t6_async_reset_outputs", all_outs(), 32'h0);
    step(2);
    check("t6_ready_low_in_reset", 32'(addrReady), 0);
    reset = 1'b0;
    step();
    check("t6_ready_after_reset", 32'(addrReady), 1);
    step(10);
    check("t6_no_readout_done", 32'(n_rddone - b_rdd), 0);
    base = n_new;
    push(8'h5a);
    push(8'h5b);
    step(8);
    check("t6_store_count", 32'(n_new - base), 2);
    check("t6_addr0", 32'(addr_q[base]), 32'h5a);
    check("t6_addr1", 32'(addr_q[base+1]), 32'h5b);
    check("t6_hit_count", 32'(hitCount), 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
